// File: rtl/md_controller.sv
// Multiply/divide sequencer beside the E-stage ALU: models operation latency with a
// busy down-counter and owns the architectural HI/LO registers.
module md_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        md_in_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   pendingHi;
    logic [31:0]   pendingLo;

    logic          longOp;
    logic [63:0]   result;
    logic [31:0]   magA, magB, quotMag, remMag;

    assign longOp  = start && (md_op inside {3'd1, 3'd2, 3'd3, 3'd4});
    assign stall_D = md_in_D && (busy || longOp);

    // Signed division goes through magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of relying on tool overflow behaviour.
    always_comb begin
        magA    = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
        magB    = SrcB[31] ? (~SrcB + 32'd1) : SrcB;
        quotMag = '0;
        remMag  = '0;
        result  = '0;
        case (md_op)
            3'd1: result = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
            3'd2: result = {32'd0, SrcA} * {32'd0, SrcB};
            3'd3: begin
                if (SrcB == '0) begin
                    result = {SrcA, 32'hFFFF_FFFF};
                end else begin
                    quotMag = magA / magB;
                    remMag  = magA % magB;
                    result[31:0]  = (SrcA[31] ^ SrcB[31]) ? (~quotMag + 32'd1) : quotMag;
                    result[63:32] = SrcA[31] ? (~remMag + 32'd1) : remMag;
                end
            end
            3'd4: begin
                if (SrcB == '0) begin
                    result = {SrcA, 32'hFFFF_FFFF};
                end else begin
                    result = {SrcA % SrcB, SrcA / SrcB};
                end
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            pendingHi <= '0;
            pendingLo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (longOp) begin
                        pendingHi <= result[63:32];
                        pendingLo <= result[31:0];
                        count     <= (md_op inside {3'd1, 3'd2}) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end else if (start && md_op == 3'd5) begin
                        HI <= SrcA;
                    end else if (start && md_op == 3'd6) begin
                        LO <= SrcA;
                    end
                end
                BUSY: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        HI    <= pendingHi;
                        LO    <= pendingLo;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_controller.sv
// Scoreboard bench for md_controller: expected HI/LO pushed when an op starts,
// popped and compared when busy drops.
module tb_md_controller;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] srcA, srcB;
    logic        mdInD;
    logic        busy, stallD;
    logic [31:0] hi, lo;

    int unsigned nCompared = 0;
    int unsigned nMismatch = 0;
    logic [63:0] expQ[$];

    md_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(mdOp),
        .SrcA(srcA), .SrcB(srcB), .md_in_D(mdInD),
        .busy(busy), .stall_D(stallD), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            3'd1: res = sa * sb;
            3'd2: res = longint'({32'd0, a}) * longint'({32'd0, b});
            3'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit watchStall, input bit interfere);
        int unsigned n;
        int unsigned nBusy;
        logic [31:0] hiBefore, loBefore;
        logic [63:0] e;
        n = (op >= 3'd3) ? DIV_N : MULT_N;
        @(negedge clk);
        hiBefore = hi;
        loBefore = lo;
        start = 1'b1; mdOp = op; srcA = a; srcB = b; mdInD = watchStall;
        expQ.push_back(model(op, a, b));
        if (watchStall) begin
            #1;
            chk("stall_at_start", 64'(stallD), 64'd1);
        end
        @(negedge clk);
        start = 1'b0; mdOp = 3'd0; srcA = $urandom; srcB = $urandom;
        nBusy = 0;
        while (busy === 1'b1 && nBusy < 64) begin
            if (watchStall) chk("stall_busy", 64'(stallD), 64'd1);
            if (interfere) begin
                chk("hi_hold", 64'(hi), 64'(hiBefore));
                chk("lo_hold", 64'(lo), 64'(loBefore));
            end
            nBusy++;
            if (interfere && nBusy == 3) begin
                start = 1'b1; mdOp = 3'd1; srcA = 32'h7; srcB = 32'h9;
            end else begin
                start = 1'b0; mdOp = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; mdOp = 3'd0;
        chk("busy_cycles", 64'(nBusy), 64'(n));
        if (watchStall) chk("stall_after", 64'(stallD), 64'd0);
        e = expQ.pop_front();
        chk("HI", 64'(hi), 64'(e[63:32]));
        chk("LO", 64'(lo), 64'(e[31:0]));
        mdInD = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mdOp = 3'd0; srcA = '0; srcB = '0; mdInD = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stallD), 64'd0);
        reset = 1'b0;

        runOp(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        runOp(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        runOp(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        runOp(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runOp(3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        runOp(3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1, 1'b1);
        runOp(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] op;
            logic [31:0] b;
            op = 3'($urandom_range(1, 4));
            b = (i == 3) ? 32'd0 : $urandom;
            runOp(op, $urandom, b, 1'b0, 1'b0);
        end

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        start = 1'b1; mdOp = 3'd5; srcA = 32'h1234;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        mdOp = 3'd6; srcA = 32'h5678;
        @(negedge clk);
        start = 1'b0; mdOp = 3'd0;
        chk("mtlo_lo", 64'(lo), 64'h5678);
        chk("mtlo_hi", 64'(hi), 64'h1234);
        chk("mtlo_busy", 64'(busy), 64'd0);

        // md_op none/reserved with start has no effect
        start = 1'b1; mdOp = 3'd7; srcA = 32'hDEAD; mdInD = 1'b1;
        #1 chk("rsvd_stall", 64'(stallD), 64'd0);
        @(negedge clk);
        mdOp = 3'd0;
        @(negedge clk);
        start = 1'b0; mdInD = 1'b0;
        chk("none_busy", 64'(busy), 64'd0);
        chk("none_hi", 64'(hi), 64'h1234);
        chk("none_lo", 64'(lo), 64'h5678);

        // reset in the middle of a mult discards the pending product
        start = 1'b1; mdOp = 3'd1; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0; mdOp = 3'd0;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
